pipelined_datapath: RTL and testbench

PIPELINED_DATAPATH -- requirements
Module: pipelined_datapath

---
 rtl/pipelined_datapath.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_pipelined_datapath.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_datapath : five-stage 32-bit pipeline (IF/ID/EX/MEM/WB) with    |
// | 256-word instruction/data memories and a 64-entry register file.          |
// | Optional macro HAZARD_UNIT_EN adds EX forwarding and a load-use stall.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+

module pd_inst_mem (
   input  logic        clk,
   input  logic        i_we,
   input  logic [7:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [7:0]  i_raddr,
   output logic [31:0] o_rdata
);
   logic [31:0] mem [0:255];

   // Load port is tied off at the top; program images are placed hierarchically.
   always_ff @(posedge clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_rdata = mem[i_raddr];
endmodule

module pd_data_mem (
   input  logic        clk,
   input  logic        i_we,
   input  logic [7:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata
);
   logic [31:0] d_mem [0:255];

   always_ff @(posedge clk) begin
      if (i_we) d_mem[i_addr] <= i_wdata;
   end

   assign o_rdata = d_mem[i_addr];
endmodule

module pd_reg_file (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_we,
   input  logic [5:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [5:0]  i_raddr_a,
   input  logic [5:0]  i_raddr_b,
   output logic [31:0] o_rdata_a,
   output logic [31:0] o_rdata_b
);
   logic [31:0] rf [0:63];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) rf[i] <= '0;
      end else if (i_we) begin
         rf[i_waddr] <= i_wdata;
      end
   end

   // Same-cycle write-to-read bypass lets WB feed ID directly.
   assign o_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : rf[i_raddr_a];
   assign o_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : rf[i_raddr_b];
endmodule

module pipelined_datapath (
   input logic clk,
   input logic reset
);
   localparam logic [3:0] c_OP_NOP  = 4'h0;
   localparam logic [3:0] c_OP_ST   = 4'h3;
   localparam logic [3:0] c_OP_ADD  = 4'h4;
   localparam logic [3:0] c_OP_INC  = 4'h5;
   localparam logic [3:0] c_OP_NEG  = 4'h6;
   localparam logic [3:0] c_OP_SUB  = 4'h7;
   localparam logic [3:0] c_OP_J    = 4'h8;
   localparam logic [3:0] c_OP_BRZ  = 4'h9;
   localparam logic [3:0] c_OP_JM   = 4'hA;
   localparam logic [3:0] c_OP_BRN  = 4'hB;
   localparam logic [3:0] c_OP_LD   = 4'hE;
   localparam logic [3:0] c_OP_SVPC = 4'hF;

   logic [31:0] r_pc;
   logic        r_flag_z, r_flag_n;
   logic [31:0] r_ifid_instr, r_ifid_pc;
   logic [3:0]  r_idex_op;
   logic [5:0]  r_idex_rd;
   logic [31:0] r_idex_a, r_idex_b, r_idex_imm, r_idex_pc;
`ifdef HAZARD_UNIT_EN
   logic [5:0]  r_idex_rs, r_idex_rt;
`endif
   logic [3:0]  r_exmem_op;
   logic [5:0]  r_exmem_rd;
   logic [31:0] r_exmem_res, r_exmem_sdata;
   logic [7:0]  r_exmem_addr;
   logic        r_memwb_we;
   logic [5:0]  r_memwb_rd;
   logic [31:0] r_memwb_data;

   logic [31:0] w_if_instr;
   logic [3:0]  w_id_raw, w_id_op;
   logic [5:0]  w_id_rd, w_id_rs, w_id_rt;
   logic [31:0] w_id_imm, w_rf_a, w_rf_b;
   logic [31:0] w_ex_a, w_ex_b, w_ex_res;
   logic        w_ex_setf, w_ex_taken, w_mem_jm, w_stall, w_dmem_we;
   logic [31:0] w_dmem_rdata;

   function automatic logic f_writes_rd(input logic [3:0] op);
      return (op == c_OP_SVPC) || (op == c_OP_INC) || (op == c_OP_ADD) ||
             (op == c_OP_SUB)  || (op == c_OP_NEG) || (op == c_OP_LD);
   endfunction

`ifdef HAZARD_UNIT_EN
   function automatic logic f_uses_rs(input logic [3:0] op);
      return (op != c_OP_NOP) && (op != c_OP_SVPC);
   endfunction

   function automatic logic f_uses_rt(input logic [3:0] op);
      return (op == c_OP_ADD) || (op == c_OP_SUB) || (op == c_OP_ST);
   endfunction
`endif

   pd_inst_mem inst_mem (
      .clk     (clk),
      .i_we    (1'b0),
      .i_waddr (8'd0),
      .i_wdata (32'd0),
      .i_raddr (r_pc[7:0]),
      .o_rdata (w_if_instr)
   );

   pd_data_mem data_mem (
      .clk     (clk),
      .i_we    (w_dmem_we),
      .i_addr  (r_exmem_addr),
      .i_wdata (r_exmem_sdata),
      .o_rdata (w_dmem_rdata)
   );

   pd_reg_file reg_file (
      .clk       (clk),
      .reset     (reset),
      .i_we      (r_memwb_we),
      .i_waddr   (r_memwb_rd),
      .i_wdata   (r_memwb_data),
      .i_raddr_a (w_id_rs),
      .i_raddr_b (w_id_rt),
      .o_rdata_a (w_rf_a),
      .o_rdata_b (w_rf_b)
   );

   // Decode; unassigned opcodes collapse to NOP here so later stages never see them.
   assign w_id_raw = r_ifid_instr[31:28];
   assign w_id_rd  = r_ifid_instr[27:22];
   assign w_id_rs  = r_ifid_instr[21:16];
   assign w_id_rt  = r_ifid_instr[15:10];

   always_comb begin
      w_id_op = w_id_raw;
      case (w_id_raw)
         4'h1, 4'h2, 4'hC, 4'hD: w_id_op = c_OP_NOP;
         default:                w_id_op = w_id_raw;
      endcase
   end

   assign w_id_imm = (w_id_op == c_OP_SVPC) ? {{10{r_ifid_instr[21]}}, r_ifid_instr[21:0]}
                                            : {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};

   always_comb begin
      w_stall = 1'b0;
`ifdef HAZARD_UNIT_EN
      if ((r_idex_op == c_OP_LD) &&
          ((f_uses_rs(w_id_op) && (r_idex_rd == w_id_rs)) ||
           (f_uses_rt(w_id_op) && (r_idex_rd == w_id_rt))))
         w_stall = 1'b1;
`endif
   end

   // EX operand select; the later assignment (EX/MEM, the younger producer) wins.
   always_comb begin
      w_ex_a = r_idex_a;
      w_ex_b = r_idex_b;
`ifdef HAZARD_UNIT_EN
      if (r_memwb_we && (r_memwb_rd == r_idex_rs)) w_ex_a = r_memwb_data;
      if (r_memwb_we && (r_memwb_rd == r_idex_rt)) w_ex_b = r_memwb_data;
      if (f_writes_rd(r_exmem_op) && (r_exmem_op != c_OP_LD) && (r_exmem_rd == r_idex_rs))
         w_ex_a = r_exmem_res;
      if (f_writes_rd(r_exmem_op) && (r_exmem_op != c_OP_LD) && (r_exmem_rd == r_idex_rt))
         w_ex_b = r_exmem_res;
`endif
   end

   always_comb begin
      w_ex_res  = '0;
      w_ex_setf = 1'b0;
      case (r_idex_op)
         c_OP_SVPC: w_ex_res = r_idex_pc + r_idex_imm;
         c_OP_INC:  begin w_ex_res = w_ex_a + r_idex_imm; w_ex_setf = 1'b1; end
         c_OP_ADD:  begin w_ex_res = w_ex_a + w_ex_b;     w_ex_setf = 1'b1; end
         c_OP_SUB:  begin w_ex_res = w_ex_a - w_ex_b;     w_ex_setf = 1'b1; end
         c_OP_NEG:  begin w_ex_res = 32'd0 - w_ex_a;      w_ex_setf = 1'b1; end
         default:   w_ex_res = '0;
      endcase
   end

   // An older JM resolving in MEM cancels whatever is currently in EX.
   assign w_mem_jm   = (r_exmem_op == c_OP_JM);
   assign w_ex_taken = !w_mem_jm &&
                       ((r_idex_op == c_OP_J) ||
                        ((r_idex_op == c_OP_BRZ) && r_flag_z) ||
                        ((r_idex_op == c_OP_BRN) && r_flag_n));
   assign w_dmem_we  = (r_exmem_op == c_OP_ST) && reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc          <= '0;
         r_flag_z      <= 1'b0;
         r_flag_n      <= 1'b0;
         r_ifid_instr  <= '0;
         r_ifid_pc     <= '0;
         r_idex_op     <= c_OP_NOP;
         r_idex_rd     <= '0;
         r_idex_a      <= '0;
         r_idex_b      <= '0;
         r_idex_imm    <= '0;
         r_idex_pc     <= '0;
`ifdef HAZARD_UNIT_EN
         r_idex_rs     <= '0;
         r_idex_rt     <= '0;
`endif
         r_exmem_op    <= c_OP_NOP;
         r_exmem_rd    <= '0;
         r_exmem_res   <= '0;
         r_exmem_sdata <= '0;
         r_exmem_addr  <= '0;
         r_memwb_we    <= 1'b0;
         r_memwb_rd    <= '0;
         r_memwb_data  <= '0;
      end else begin
         if (w_mem_jm)        r_pc <= w_dmem_rdata;
         else if (w_ex_taken) r_pc <= w_ex_a;
         else if (!w_stall)   r_pc <= r_pc + 32'd1;

         if (w_ex_setf && !w_mem_jm) begin
            r_flag_z <= (w_ex_res == 32'd0);
            r_flag_n <= w_ex_res[31];
         end

         if (w_mem_jm || w_ex_taken) begin
            r_ifid_instr <= '0;
            r_ifid_pc    <= '0;
         end else if (!w_stall) begin
            r_ifid_instr <= w_if_instr;
            r_ifid_pc    <= r_pc;
         end

         if (w_mem_jm || w_ex_taken || w_stall) begin
            r_idex_op <= c_OP_NOP;
            r_idex_rd <= '0;
         end else begin
            r_idex_op  <= w_id_op;
            r_idex_rd  <= w_id_rd;
            r_idex_a   <= w_rf_a;
            r_idex_b   <= w_rf_b;
            r_idex_imm <= w_id_imm;
            r_idex_pc  <= r_ifid_pc;
`ifdef HAZARD_UNIT_EN
            r_idex_rs  <= w_id_rs;
            r_idex_rt  <= w_id_rt;
`endif
         end

         if (w_mem_jm) begin
            r_exmem_op <= c_OP_NOP;
            r_exmem_rd <= '0;
         end else begin
            r_exmem_op    <= r_idex_op;
            r_exmem_rd    <= r_idex_rd;
            r_exmem_res   <= w_ex_res;
            r_exmem_addr  <= w_ex_a[7:0];
            r_exmem_sdata <= w_ex_b;
         end

         r_memwb_we   <= f_writes_rd(r_exmem_op);
         r_memwb_rd   <= r_exmem_rd;
         r_memwb_data <= (r_exmem_op == c_OP_LD) ? w_dmem_rdata : r_exmem_res;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pipelined_datapath.sv
`default_nettype none
// tb_pipelined_datapath : directed programs with hand-computed register,
// memory, PC and flag expectations for pipelined_datapath.
module tb_pipelined_datapath;
   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] img [0:255];

   pipelined_datapath dut (
      .clk   (clk),
      .reset (reset)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] f_r(input logic [3:0] op, input int rd, input int rs, input int rt);
      return {op, 6'(rd), 6'(rs), 6'(rt), 10'd0};
   endfunction

   function automatic logic [31:0] f_inc(input int rd, input int rs, input int imm);
      return {4'h5, 6'(rd), 6'(rs), 16'(imm)};
   endfunction

   function automatic logic [31:0] f_svpc(input int rd, input int imm);
      return {4'hF, 6'(rd), 22'(imm)};
   endfunction

   function automatic logic [31:0] rf_or();
      logic [31:0] acc = '0;
      for (int i = 0; i < 64; i++) acc |= dut.reg_file.rf[i];
      return acc;
   endfunction

   task automatic clear_img();
      for (int i = 0; i < 256; i++) img[i] = 32'd0;
   endtask

   // Hold reset, load the image, release on a falling edge: next rising edge fetches mem[0].
   task automatic start_prog();
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) dut.inst_mem.mem[i] = img[i];
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic brn_prog(input int a, input int b);
      clear_img();
      img[0]  = f_inc(1, 0, a);
      img[1]  = f_inc(2, 0, b);
      img[2]  = f_inc(6, 0, 20);
      img[4]  = f_r(4'h7, 8, 1, 2);
      img[5]  = f_r(4'hB, 0, 6, 0);
      img[6]  = f_inc(20, 0, 1);
      img[7]  = f_inc(21, 0, 1);
      img[20] = f_inc(14, 0, 9);
      start_prog();
   endtask

   initial begin
      logic seen;

      // Reset state
      run(2);
      check_val("reset_pc", dut.r_pc, 32'd0);
      check_val("reset_flags", {30'd0, dut.r_flag_z, dut.r_flag_n}, 32'd0);
      check_val("reset_rf", rf_or(), 32'd0);
      check_val("reset_ifid", dut.r_ifid_instr, 32'd0);

      // Arithmetic with NOP spacing; x0 written as an ordinary register
      clear_img();
      img[0] = f_inc(1, 0, 5);
      img[1] = f_inc(2, 0, 3);
      img[2] = f_inc(0, 0, 33);
      img[4] = f_r(4'h4, 9, 1, 2);
      img[5] = f_r(4'h7, 10, 1, 2);
      img[6] = f_r(4'h6, 11, 1, 0);
      start_prog();
      run(20);
      check_val("pc_advance", dut.r_pc, 32'd20);
      check_val("add_x9", dut.reg_file.rf[9], 32'd8);
      check_val("sub_x10", dut.reg_file.rf[10], 32'd2);
      check_val("neg_x11", dut.reg_file.rf[11], 32'hFFFF_FFFB);
      check_val("x0_write", dut.reg_file.rf[0], 32'd33);
      check_val("neg_flags_zn", {30'd0, dut.r_flag_z, dut.r_flag_n}, 32'd1);

      // Store then load
      clear_img();
      img[0] = f_inc(1, 0, 5);
      img[1] = f_inc(2, 0, 3);
      img[4] = f_r(4'h3, 0, 1, 2);
      img[5] = f_r(4'hE, 5, 1, 0);
      img[9] = f_r(4'h4, 12, 5, 5);
      start_prog();
      run(20);
      check_val("st_dmem5", dut.data_mem.d_mem[5], 32'd3);
      check_val("ld_x5", dut.reg_file.rf[5], 32'd3);
      check_val("ld_use_x12", dut.reg_file.rf[12], 32'd6);

`ifdef HAZARD_UNIT_EN
      // Back-to-back dependencies: forwarding plus exactly one load-use stall
      clear_img();
      img[0] = f_inc(1, 0, 9);
      img[1] = f_inc(2, 0, 3);
      img[2] = f_r(4'h3, 0, 1, 2);
      img[3] = f_r(4'hE, 5, 1, 0);
      img[4] = f_r(4'h4, 12, 5, 2);
      start_prog();
      run(20);
      check_val("hz_stall_pc", dut.r_pc, 32'd19);
      check_val("hz_fwd_st", dut.data_mem.d_mem[9], 32'd3);
      check_val("hz_ld_use", dut.reg_file.rf[12], 32'd6);
`endif

      // SVPC and taken BRZ
      clear_img();
      img[0]  = f_svpc(4, 2);
      img[1]  = f_inc(3, 0, 12);
      img[4]  = f_r(4'h7, 0, 3, 3);
      img[5]  = f_r(4'h9, 0, 3, 0);
      img[6]  = f_inc(20, 0, 1);
      img[7]  = f_inc(21, 0, 1);
      img[8]  = f_inc(22, 0, 1);
      img[12] = f_inc(13, 0, 7);
      start_prog();
      run(8);
      check_val("brz_pc", dut.r_pc, 32'd12);
      check_val("brz_zflag", {31'd0, dut.r_flag_z}, 32'd1);
      run(12);
      check_val("svpc_x4", dut.reg_file.rf[4], 32'd2);
      check_val("brz_squash", dut.reg_file.rf[20] | dut.reg_file.rf[21] | dut.reg_file.rf[22], 32'd0);
      check_val("brz_target_x13", dut.reg_file.rf[13], 32'd7);

      // BRN taken (3-5 negative)
      brn_prog(3, 5);
      run(8);
      check_val("brn_taken_pc", dut.r_pc, 32'd20);
      check_val("brn_nflag", {31'd0, dut.r_flag_n}, 32'd1);
      run(12);
      check_val("brn_sub_x8", dut.reg_file.rf[8], 32'hFFFF_FFFE);
      check_val("brn_squash", dut.reg_file.rf[20] | dut.reg_file.rf[21], 32'd0);
      check_val("brn_target_x14", dut.reg_file.rf[14], 32'd9);

      // BRN not taken (5-3 positive)
      brn_prog(5, 3);
      run(8);
      check_val("brn_nt_pc", dut.r_pc, 32'd8);
      run(12);
      check_val("brn_nt_x20", dut.reg_file.rf[20], 32'd1);
      check_val("brn_nt_x14", dut.reg_file.rf[14], 32'd0);

      // JM through d_mem[7]=16; squashed slot 7 would set N if it ran
      clear_img();
      img[0]  = f_inc(7, 0, 7);
      img[1]  = f_inc(15, 0, 16);
      img[4]  = f_r(4'h3, 0, 7, 15);
      img[6]  = f_r(4'hA, 0, 7, 0);
      img[7]  = f_inc(20, 0, 16'hFFFF);
      img[8]  = f_inc(21, 0, 1);
      img[9]  = f_inc(22, 0, 1);
      img[10] = f_inc(23, 0, 1);
      img[16] = f_inc(16, 0, 3);
      start_prog();
      run(10);
      check_val("jm_pc", dut.r_pc, 32'd16);
      check_val("jm_nflag_kept", {31'd0, dut.r_flag_n}, 32'd0);
      run(10);
      check_val("jm_dmem7", dut.data_mem.d_mem[7], 32'd16);
      check_val("jm_squash", dut.reg_file.rf[20] | dut.reg_file.rf[21] |
                             dut.reg_file.rf[22] | dut.reg_file.rf[23], 32'd0);
      check_val("jm_target_x16", dut.reg_file.rf[16], 32'd3);

      // Reset while an ST sits in MEM: d_mem[5] must keep 3
      clear_img();
      img[0] = f_inc(1, 0, 5);
      img[1] = f_inc(24, 0, 99);
      img[4] = f_r(4'h3, 0, 1, 24);
      start_prog();
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (dut.r_exmem_op == 4'h3) seen = 1'b1;
      end
      check_val("st_reached_mem", {31'd0, seen}, 32'd1);
      reset = 1'b0;
      run(2);
      check_val("rst_no_dmem_write", dut.data_mem.d_mem[5], 32'd3);
      check_val("rst_rf_clear", rf_or(), 32'd0);
      check_val("rst_pc", dut.r_pc, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      run(1);
      check_val("restart_fetch0", dut.r_ifid_instr, f_inc(1, 0, 5));
      check_val("restart_pc", dut.r_pc, 32'd1);
      run(8);
      check_val("restart_x1", dut.reg_file.rf[1], 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
